// File: rtl/cdc_req_tx_if.sv
`default_nettype none
// ============================================================================
// cdc_req_tx_if : word/handshake bundle of the four-phase req/ack transmitter
// Revision      : 1.0
// ============================================================================
interface cdc_req_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             xreq;
  logic [WIDTH-1:0] xdata;
  logic             xack_async;
  logic             done;
  logic             timeout;

  modport master (
    input  in_valid, in_data, xack_async,
    output in_ready, xreq, xdata, done, timeout
  );

  modport slave (
    output in_valid, in_data, xack_async,
    input  in_ready, xreq, xdata, done, timeout
  );
endinterface
`default_nettype wire

// File: rtl/cdc_req_tx.sv
`default_nettype none
// ============================================================================
// cdc_req_tx : transmit side of a four-phase req/ack clock-domain crossing
// Revision   : 1.0
// ============================================================================
module cdc_req_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  wire logic    sysclk,
  input  wire logic    rst_n,
  cdc_req_tx_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  state_t                 r_state;
  logic                   r_live;
  logic                   r_xreq;
  logic [WIDTH-1:0]       r_xdata;
  logic                   r_done;
  logic                   w_in_ready;
  logic                   w_accept;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.xack_async};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // r_live holds in_ready low while reset is asserted and for the release edge.
  assign w_in_ready = (r_state == S_IDLE) && r_live && !w_ack_s;
  assign w_accept   = w_in_ready && bus.in_valid;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_xreq  <= 1'b0;
      r_xdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_xdata <= bus.in_data;
            r_xreq  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack_s) begin
            r_xreq  <= 1'b0;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!w_ack_s) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_xreq  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.xreq     = r_xreq;
  assign bus.xdata    = r_xdata;
  assign bus.done     = r_done;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] r_phase_cnt;
      logic             r_timeout;
      logic             w_waiting;
      logic             w_state_change;

      assign w_waiting      = (r_state == S_REQ) || (r_state == S_RELEASE);
      assign w_state_change = w_accept
                            || ((r_state == S_REQ) && w_ack_s)
                            || ((r_state == S_RELEASE) && !w_ack_s);

      // Flag on the same edge the counter reaches TIMEOUT; the handshake keeps waiting.
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          r_phase_cnt <= '0;
          r_timeout   <= 1'b0;
        end else begin
          if (w_state_change) begin
            r_phase_cnt <= '0;
          end else if (w_waiting && (r_phase_cnt != CNT_MAX)) begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end

          if (w_accept) begin
            r_timeout <= 1'b0;
          end else if (w_waiting && !w_state_change && (r_phase_cnt >= CNT_LAST)) begin
            r_timeout <= 1'b1;
          end
        end
      end

      assign bus.timeout = r_timeout;
    end else begin : g_no_timeout
      assign bus.timeout = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/cdc_req_tx.md
# cdc_req_tx

Transmit side of a four-phase req/ack clock-domain crossing: captures a parallel word in the `sysclk` domain and presents it, with a level request, to a receiver in an unrelated clock domain. The receiver synchronizes `xreq` with its own synchronizer chain and returns an asynchronous acknowledge. This block synchronizes that acknowledge internally and sequences the four-phase protocol. It sits at the boundary of the `sysclk` domain, paired with a synchronizer-based receiver on the far side.

## Interface
- `WIDTH`, 8: bit-width of the transferred word.
- `SYNC_STAGES`, 2: flip-flop stages on the `xack_async` synchronizer; minimum 2.
- `TIMEOUT`, 0: cycles allowed per handshake phase before `timeout` is flagged; 0 disables the check.

- `sysclk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  local word available.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  local word, sampled when `in_valid && in_ready`.
- `xreq`  out  1  request to far domain; registered, glitch-free.
- `xdata`  out  WIDTH  word to far domain; registered, stable whenever `xreq`=1.
- `xack_async`  in  1  acknowledge from far domain, asynchronous.
- `done`  out  1  one-cycle pulse when a handshake completes.
- `timeout`  out  1  sticky phase-timeout flag.

## Operation
- Internal chain: `SYNC_STAGES` flops on `xack_async`, reset to 0. `ack_s` is the last stage. Only `ack_s` is used in logic.
- FSM states: IDLE, REQ, RELEASE.
  - IDLE: `in_ready = !ack_s`. On `in_valid && in_ready`, load `xdata <= in_data`, set `xreq <= 1`, and go to REQ. `in_valid` while `ack_s`=1 is ignored.
  - REQ: `xreq`=1. When `ack_s`=1, set `xreq <= 0` and go to RELEASE.
  - RELEASE: `xreq`=0. When `ack_s`=0, pulse `done`, go to IDLE.
- `in_ready` is 0 in REQ and RELEASE. There is no queueing; the source holds `in_valid`/`in_data` until accepted.
- `xdata` is written only on accept. It holds its value after completion until the next accept.
- Timeout (`TIMEOUT`>0):
  - A phase counter clears on every state change and increments while in REQ or RELEASE.
  - When it reaches `TIMEOUT`, `timeout <= 1`. The FSM keeps waiting; it never aborts a handshake.
  - `timeout` clears on the next accept.
  - Counter width is `$clog2(TIMEOUT+1)`, saturating.
- Reset (any time, including mid-handshake):
  - State returns to IDLE.
  - Outputs: `xreq`=0, `xdata`=0, `done`=0, `timeout`=0, and the sync chain is cleared.
  - `in_ready`=1 one cycle after reset release if `ack_s`=0.
  - The far side must tolerate a withdrawn `xreq`.

## Timing
- Accept at rising edge k: `xreq`=1 and `xdata` valid from edge k onward.
- `xack_async` rising, first sampled at edge m: `ack_s`=1 after edge m+SYNC_STAGES-1, and `xreq` falls at edge m+SYNC_STAGES.
- `xack_async` falling, first sampled at edge n: state is IDLE and `done`=1 after edge n+SYNC_STAGES. `in_ready`=1 in that same cycle.
- A new word may be accepted in the `done` cycle.
- Minimum transfer period with an instantly responding far side: 2·(SYNC_STAGES+1)+1 cycles, plus far-side latency.
- `done` is a single cycle; it is never asserted in REQ.

## Test plan
- Reset/basic transfer: `rst_n`=0 → all outputs 0.
  - Release, `in_data`=8'hA5 with `in_valid` → `xreq`=1 and `xdata`=8'hA5 next cycle, `in_ready`=0.
  - Model far side with a 2-flop sync and 3-cycle response → `done` pulses once and `xdata` still reads 8'hA5.
- Ack latency: raise `xack_async` just before edge m (SYNC_STAGES=2) → `xreq` falls exactly at edge m+2.
  - Drop it before edge n → `done`=1 exactly after edge n+2.
- Back-to-back: hold `in_valid` with 8'h01, 8'h02, 8'h03 → each accepted in its `done` cycle, `xdata` sequence 01, 02, 03, no word lost or duplicated, `xreq` never high with `ack_s` high in IDLE.
- Stale ack: hold `xack_async`=1 out of reset → `in_ready`=0, `in_valid` ignored.
  - Drop ack → `in_ready`=1 SYNC_STAGES cycles later.
- Timeout: TIMEOUT=10, far side never acks → `timeout`=1 after 10 cycles in REQ, `xreq` stays 1.
  - Ack later → handshake completes normally, `timeout` stays 1 until the next accept.
- Mid-handshake reset: assert `rst_n`=0 while in REQ → `xreq`, `xdata`, `done`, `timeout` = 0 immediately, without a clock edge.
  - After release with `xack_async`=0 → `in_ready`=1 within SYNC_STAGES cycles.
